// File: rtl/neosd_pkg.sv
// Shared types and constants for the NEOSD command-line PHY.
// Holds the response-mode and FSM state encodings plus frame lengths.
package neosd_pkg;

    typedef enum logic [1:0] {
        RmNone       = 2'd0,
        RmShort      = 2'd1,
        RmShortNoCrc = 2'd2,
        RmLong       = 2'd3
    } rmode_e;

    typedef enum logic [2:0] {
        StIdle,
        StTx,
        StWait,
        StRx,
        StNcc
    } state_e;

    localparam int unsigned CMD_BITS   = 48;
    localparam int unsigned CRC_SPAN   = 40;
    localparam int unsigned RESP_SHORT = 48;
    localparam int unsigned RESP_LONG  = 136;

    function automatic logic [7:0] resp_len(rmode_e mode);
        return (mode == RmLong) ? 8'(RESP_LONG) : 8'(RESP_SHORT);
    endfunction

endpackage

// File: rtl/neosd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), zero initial value, MSB-first data.
// clr_i wins over en_i; crc_o is the register value after the last enabled bit.
module neosd_crc7 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       din_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q;
    logic       fb;

    assign fb    = din_i ^ crc_q[6];
    assign crc_o = crc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            crc_q <= '0;
        end else if (en_i) begin
            crc_q <= {crc_q[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
        end
    end

endmodule

// File: rtl/neosd_cmd_phy.sv
// SD-card CMD line PHY: sends a 48-bit command, optionally receives an R1/R3/R2
// response, then drives the NCC idle clocks. One shared CRC7 serves TX and RX.
module neosd_cmd_phy
    import neosd_pkg::*;
#(
    parameter int unsigned CDIV_W  = 8,
    parameter int unsigned NCR_MAX = 64,
    parameter int unsigned NCC_MIN = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CDIV_W-1:0] cdiv_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [5:0]        idx_i,
    input  logic [31:0]       arg_i,
    input  logic [1:0]        rmode_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic              crc_err_o,
    output logic [135:0]      resp_o,
    output logic              sd_clk_o,
    output logic              sd_cmd_o,
    output logic              sd_cmd_oe,
    input  logic              sd_cmd_i
);

    localparam int unsigned WAIT_W = $clog2(NCR_MAX + 1);
    localparam int unsigned NCC_W  = $clog2(NCC_MIN + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(NCR_MAX - 1);
    localparam logic [NCC_W-1:0]  NCC_LAST  = NCC_W'(NCC_MIN - 1);

    state_e              state_q, state_d;
    rmode_e              rmode_q;
    logic [CDIV_W-1:0]   cdiv_q, div_cnt_q;
    logic                sd_clk_q;
    logic [47:0]         tx_sr_q;
    logic [5:0]          bit_cnt_q;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic [NCC_W-1:0]    ncc_cnt_q;
    logic [7:0]          rx_cnt_q;
    logic [135:0]        rx_sr_q, resp_q;
    logic                done_q, timeout_q, crc_err_q;

    logic                tick, sd_rise, sd_fall, done_d;
    logic                crc_clr, crc_en, crc_din;
    logic [6:0]          crc;
    logic [2:0]          crc_idx;
    logic [7:0]          rx_len;

    // SD clock edges are decided one clk_i cycle ahead: a "rise" cycle is the
    // one whose edge drives sd_clk_o high.
    assign tick    = (state_q != StIdle) && (div_cnt_q == cdiv_q);
    assign sd_rise = tick && !sd_clk_q;
    assign sd_fall = tick && sd_clk_q;
    assign rx_len  = resp_len(rmode_q);
    assign crc_idx = 3'(6'd46 - bit_cnt_q);

    assign busy_o    = (state_q != StIdle);
    assign done_o    = done_q;
    assign timeout_o = timeout_q;
    assign crc_err_o = crc_err_q;
    assign resp_o    = resp_q;
    assign sd_clk_o  = sd_clk_q;

    neosd_crc7 u_crc7 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (crc_clr),
        .en_i  (crc_en),
        .din_i (crc_din),
        .crc_o (crc)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: if (start_i) state_d = StTx;
                StTx: begin
                    if (sd_fall && bit_cnt_q == 6'd47) begin
                        state_d = (rmode_q == RmNone) ? StNcc : StWait;
                    end
                end
                StWait: begin
                    if (sd_rise && !sd_cmd_i) begin
                        state_d = StRx;
                    end else if (sd_fall && wait_cnt_q == WAIT_LAST) begin
                        state_d = StNcc;
                    end
                end
                StRx: if (sd_fall && rx_cnt_q == rx_len) state_d = StNcc;
                StNcc: if (sd_fall && ncc_cnt_q == NCC_LAST) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        sd_cmd_oe = 1'b0;
        sd_cmd_o  = 1'b1;
        crc_clr   = 1'b0;
        crc_en    = 1'b0;
        crc_din   = sd_cmd_i;
        done_d    = 1'b0;
        case (state_q)
            StIdle: crc_clr = start_i;
            StTx: begin
                sd_cmd_oe = 1'b1;
                sd_cmd_o  = (bit_cnt_q >= 6'd40 && bit_cnt_q < 6'd47) ? crc[crc_idx]
                                                                      : tx_sr_q[47];
                crc_din   = tx_sr_q[47];
                crc_en    = sd_fall && (bit_cnt_q < 6'(CRC_SPAN));
                // Fresh CRC for the response, whose start bit may arrive next.
                crc_clr   = sd_fall && (bit_cnt_q == 6'd47);
            end
            StWait: crc_en = sd_rise && !sd_cmd_i && (rmode_q != RmLong);
            StRx: begin
                if (rmode_q == RmLong) begin
                    crc_en = sd_rise && (rx_cnt_q >= 8'd8) && (rx_cnt_q < 8'd128);
                end else begin
                    crc_en = sd_rise && (rx_cnt_q < 8'(CRC_SPAN));
                end
            end
            StNcc: begin
                sd_cmd_oe = 1'b1;
                done_d    = sd_fall && (ncc_cnt_q == NCC_LAST) && !abort_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rmode_q    <= RmNone;
            cdiv_q     <= '0;
            div_cnt_q  <= '0;
            sd_clk_q   <= 1'b0;
            tx_sr_q    <= '0;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            ncc_cnt_q  <= '0;
            rx_cnt_q   <= '0;
            rx_sr_q    <= '0;
            resp_q     <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            crc_err_q  <= 1'b0;
        end else if (abort_i) begin
            div_cnt_q <= '0;
            sd_clk_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= done_d;
            if (state_q == StIdle) begin
                div_cnt_q <= '0;
                sd_clk_q  <= 1'b0;
                if (start_i) begin
                    rmode_q    <= rmode_e'(rmode_i);
                    cdiv_q     <= cdiv_i;
                    tx_sr_q    <= {2'b01, idx_i, arg_i, 7'h00, 1'b1};
                    bit_cnt_q  <= '0;
                    wait_cnt_q <= '0;
                    ncc_cnt_q  <= '0;
                    rx_cnt_q   <= '0;
                    rx_sr_q    <= '0;
                    timeout_q  <= 1'b0;
                    crc_err_q  <= 1'b0;
                end
            end else begin
                if (tick) begin
                    div_cnt_q <= '0;
                    sd_clk_q  <= ~sd_clk_q;
                end else begin
                    div_cnt_q <= div_cnt_q + 1'b1;
                end
                case (state_q)
                    StTx: begin
                        if (sd_fall) begin
                            tx_sr_q   <= {tx_sr_q[46:0], 1'b1};
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                        end
                    end
                    StWait: begin
                        if (sd_rise && !sd_cmd_i) begin
                            rx_sr_q  <= {rx_sr_q[134:0], 1'b0};
                            rx_cnt_q <= 8'd1;
                        end else if (sd_fall) begin
                            wait_cnt_q <= wait_cnt_q + 1'b1;
                            if (wait_cnt_q == WAIT_LAST) timeout_q <= 1'b1;
                        end
                    end
                    StRx: begin
                        if (sd_rise) begin
                            rx_sr_q  <= {rx_sr_q[134:0], sd_cmd_i};
                            rx_cnt_q <= rx_cnt_q + 8'd1;
                        end else if (sd_fall && rx_cnt_q == rx_len) begin
                            resp_q    <= (rmode_q == RmLong) ? rx_sr_q
                                                             : {88'b0, rx_sr_q[47:0]};
                            crc_err_q <= !rx_sr_q[0] ||
                                         ((rmode_q != RmShortNoCrc) && (crc != rx_sr_q[7:1]));
                        end
                    end
                    StNcc: if (sd_fall) ncc_cnt_q <= ncc_cnt_q + 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_neosd_cmd_phy.sv
// Directed bench for neosd_cmd_phy: a vector table of full transactions against
// a small SD-card model, plus hand sequences for abort, reset and start corners.
module tb_neosd_cmd_phy;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic [7:0]   cdiv_i = '0;
    logic         start_i = 1'b0;
    logic         abort_i = 1'b0;
    logic [5:0]   idx_i = '0;
    logic [31:0]  arg_i = '0;
    logic [1:0]   rmode_i = '0;
    logic         busy_o, done_o, timeout_o, crc_err_o;
    logic [135:0] resp_o;
    logic         sd_clk_o, sd_cmd_o, sd_cmd_oe;
    logic         sd_cmd_i = 1'b1;

    neosd_cmd_phy dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .cdiv_i    (cdiv_i),
        .start_i   (start_i),
        .abort_i   (abort_i),
        .idx_i     (idx_i),
        .arg_i     (arg_i),
        .rmode_i   (rmode_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .timeout_o (timeout_o),
        .crc_err_o (crc_err_o),
        .resp_o    (resp_o),
        .sd_clk_o  (sd_clk_o),
        .sd_cmd_o  (sd_cmd_o),
        .sd_cmd_oe (sd_cmd_oe),
        .sd_cmd_i  (sd_cmd_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   cdiv;
        logic [5:0]   idx;
        logic [31:0]  arg;
        logic [1:0]   rmode;
        bit           rep_en;
        logic [135:0] rep;
        int           rep_len;
        int           rep_dly;
        logic [47:0]  exp_frame;
        int           exp_clks;
        logic         exp_to;
        logic         exp_ce;
        logic [135:0] exp_resp;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Card model state
    logic         prev_clk = 1'b0;
    int           host_bits, rises, fall_n, rep_k, ndone, contention;
    logic [47:0]  frame;
    bit           rep_en;
    logic [135:0] rep_val;
    int           rep_len, rep_dly;
    logic         last_to, last_ce, last_busy;
    logic [135:0] last_resp;

    function automatic logic [6:0] crc7_of(input logic [135:0] v, input int hi, input int lo);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = hi; i >= lo; i--) begin
            fb = v[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [47:0] f;
        f      = {2'b01, idx, arg, 7'h00, 1'b1};
        f[7:1] = crc7_of({88'b0, f}, 47, 8);
        return f;
    endfunction

    function automatic vec_t mkv(input logic [7:0] cdiv, input logic [5:0] idx,
                                 input logic [31:0] arg, input logic [1:0] rmode,
                                 input bit ren, input logic [135:0] rep, input int rlen,
                                 input int rdly, input logic [47:0] fr, input int clks,
                                 input logic to, input logic ce, input logic [135:0] resp);
        vec_t v;
        v.cdiv = cdiv; v.idx = idx; v.arg = arg; v.rmode = rmode;
        v.rep_en = ren; v.rep = rep; v.rep_len = rlen; v.rep_dly = rdly;
        v.exp_frame = fr; v.exp_clks = clks; v.exp_to = to; v.exp_ce = ce;
        v.exp_resp = resp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset(input bit en, input logic [135:0] val, input int len,
                               input int dly);
        host_bits = 0; rises = 0; fall_n = 0; rep_k = 0; ndone = 0; contention = 0;
        frame = '0; rep_en = en; rep_val = val; rep_len = len; rep_dly = dly;
        sd_cmd_i = 1'b1;
    endtask

    // One clk_i cycle of the card: watches SD clock edges at the negedge of clk.
    task automatic tick_model();
        @(negedge clk);
        if (done_o) begin
            ndone++;
            last_to = timeout_o; last_ce = crc_err_o; last_resp = resp_o; last_busy = busy_o;
        end
        if (sd_clk_o && !prev_clk) begin
            rises++;
            if (host_bits < 48 && sd_cmd_oe) begin
                frame = {frame[46:0], sd_cmd_o};
                host_bits++;
            end
        end
        if (!sd_clk_o && prev_clk && host_bits == 48 && rep_en) begin
            fall_n++;
            if (fall_n >= rep_dly + 1 && rep_k < rep_len) begin
                sd_cmd_i = rep_val[rep_len - 1 - rep_k];
                rep_k++;
            end else begin
                sd_cmd_i = 1'b1;
            end
        end
        if (sd_cmd_oe && rep_k > 0 && rep_k < rep_len) contention++;
        prev_clk = sd_clk_o;
    endtask

    task automatic start_cmd(input logic [7:0] cdiv, input logic [5:0] idx,
                             input logic [31:0] arg, input logic [1:0] rmode);
        cdiv_i = cdiv; idx_i = idx; arg_i = arg; rmode_i = rmode;
        start_i = 1'b1;
        tick_model();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int post;
        post = 0;
        for (int c = 0; c < budget && post < 40; c++) begin
            tick_model();
            if (ndone > 0) post++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int n);
        model_reset(v.rep_en, v.rep, v.rep_len, v.rep_dly);
        start_cmd(v.cdiv, v.idx, v.arg, v.rmode);
        chk($sformatf("v%0d_busy_rise", n), {135'b0, busy_o}, 136'd1);
        wait_done(6000);
        chk($sformatf("v%0d_done_count", n), 136'(ndone), 136'd1);
        chk($sformatf("v%0d_frame", n), {88'b0, frame}, {88'b0, v.exp_frame});
        chk($sformatf("v%0d_sd_clocks", n), 136'(rises), 136'(v.exp_clks));
        chk($sformatf("v%0d_timeout", n), {135'b0, last_to}, {135'b0, v.exp_to});
        chk($sformatf("v%0d_crc_err", n), {135'b0, last_ce}, {135'b0, v.exp_ce});
        chk($sformatf("v%0d_resp", n), last_resp, v.exp_resp);
        chk($sformatf("v%0d_busy_at_done", n), {135'b0, last_busy}, 136'd0);
        chk($sformatf("v%0d_contention", n), 136'(contention), 136'd0);
    endtask

    vec_t         vecs[8];
    logic [135:0] r7, r7_bad, r7_end0, r2;
    logic [119:0] cid;

    initial begin
        r7      = {88'b0, 48'h08000001AA13};
        r7_bad  = {88'b0, 48'h08000001AA11};
        r7_end0 = {88'b0, 48'h08000001AA12};
        cid     = 120'h035344535531364780123456780123;
        r2      = {2'b00, 6'h3F, cid, 7'h00, 1'b1};
        r2[7:1] = crc7_of(r2, 127, 8);

        vecs[0] = mkv(8'd1, 6'd0, 32'h0, 2'd0, 1'b0, '0, 0, 0,
                      48'h400000000095, 56, 1'b0, 1'b0, '0);
        vecs[1] = mkv(8'd1, 6'd8, 32'h1AA, 2'd1, 1'b1, r7, 48, 2,
                      48'h48000001AA87, 106, 1'b0, 1'b0, r7);
        vecs[2] = mkv(8'd1, 6'd8, 32'h1AA, 2'd1, 1'b1, r7_bad, 48, 2,
                      48'h48000001AA87, 106, 1'b0, 1'b1, r7_bad);
        vecs[3] = mkv(8'd1, 6'd8, 32'h1AA, 2'd2, 1'b1, r7_bad, 48, 2,
                      48'h48000001AA87, 106, 1'b0, 1'b0, r7_bad);
        vecs[4] = mkv(8'd0, 6'd8, 32'h1AA, 2'd1, 1'b0, '0, 0, 0,
                      48'h48000001AA87, 48 + 64 + 8, 1'b1, 1'b0, r7_bad);
        vecs[5] = mkv(8'd0, 6'd2, 32'h0, 2'd3, 1'b1, r2, 136, 2,
                      mk_frame(6'd2, 32'h0), 194, 1'b0, 1'b0, r2);
        vecs[6] = mkv(8'd1, 6'd41, 32'h40FF8000, 2'd2, 1'b1, r7_end0, 48, 2,
                      mk_frame(6'd41, 32'h40FF8000), 106, 1'b0, 1'b1, r7_end0);
        vecs[7] = mkv(8'd3, 6'd17, 32'h00001234, 2'd0, 1'b0, '0, 0, 0,
                      mk_frame(6'd17, 32'h00001234), 56, 1'b0, 1'b0, r7_end0);

        // Reset state
        model_reset(1'b0, '0, 0, 0);
        repeat (3) tick_model();
        chk("rst_busy", {135'b0, busy_o}, 136'd0);
        chk("rst_done", {135'b0, done_o}, 136'd0);
        chk("rst_sd_clk", {135'b0, sd_clk_o}, 136'd0);
        chk("rst_sd_cmd", {135'b0, sd_cmd_o}, 136'd1);
        chk("rst_sd_cmd_oe", {135'b0, sd_cmd_oe}, 136'd0);
        chk("rst_timeout", {135'b0, timeout_o}, 136'd0);
        chk("rst_crc_err", {135'b0, crc_err_o}, 136'd0);
        chk("rst_resp", resp_o, '0);
        rst_i = 1'b0;
        tick_model();

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // start_i while busy is ignored
        model_reset(1'b0, '0, 0, 0);
        start_cmd(8'd0, 6'd0, 32'h0, 2'd0);
        repeat (10) tick_model();
        start_cmd(8'd2, 6'd5, 32'hFFFF_FFFF, 2'd1);
        wait_done(3000);
        chk("busy_restart_frame", {88'b0, frame}, {88'b0, 48'h400000000095});
        chk("busy_restart_done", 136'(ndone), 136'd1);
        chk("busy_restart_clocks", 136'(rises), 136'd56);

        // abort_i in the middle of TX
        model_reset(1'b0, '0, 0, 0);
        start_cmd(8'd1, 6'd8, 32'h1AA, 2'd1);
        for (int c = 0; c < 2000 && host_bits < 20; c++) tick_model();
        chk("abort_reached_bit20", 136'(host_bits), 136'd20);
        abort_i = 1'b1;
        tick_model();
        abort_i = 1'b0;
        chk("abort_busy", {135'b0, busy_o}, 136'd0);
        chk("abort_oe", {135'b0, sd_cmd_oe}, 136'd0);
        chk("abort_sd_clk", {135'b0, sd_clk_o}, 136'd0);
        repeat (300) tick_model();
        chk("abort_no_done", 136'(ndone), 136'd0);

        // start_i and abort_i together: abort wins
        model_reset(1'b0, '0, 0, 0);
        abort_i = 1'b1;
        start_cmd(8'd0, 6'd0, 32'h0, 2'd0);
        abort_i = 1'b0;
        chk("start_abort_busy", {135'b0, busy_o}, 136'd0);
        repeat (100) tick_model();
        chk("start_abort_no_done", 136'(ndone), 136'd0);
        chk("start_abort_no_clock", 136'(rises), 136'd0);

        // rst_i during RX
        model_reset(1'b1, r7, 48, 2);
        start_cmd(8'd1, 6'd8, 32'h1AA, 2'd1);
        for (int c = 0; c < 3000 && rep_k < 10; c++) tick_model();
        chk("rx_reached", 136'(rep_k), 136'd10);
        rst_i = 1'b1;
        tick_model();
        rst_i = 1'b0;
        sd_cmd_i = 1'b1;
        chk("rxrst_busy", {135'b0, busy_o}, 136'd0);
        chk("rxrst_oe", {135'b0, sd_cmd_oe}, 136'd0);
        chk("rxrst_sd_clk", {135'b0, sd_clk_o}, 136'd0);
        chk("rxrst_resp", resp_o, '0);
        rep_en = 1'b0;
        repeat (300) tick_model();
        chk("rxrst_no_done", 136'(ndone), 136'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
